// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and constants for the T flip-flop counter sequencer.
package tff_count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_stage.sv
// One T flip-flop bit with a synchronous parallel load; load beats toggle.
// Latency: q updates on the clk edge after t/load. Backpressure: none.
module tff_stage
    import tff_count_ctrl_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic t,
    input  logic d_load,
    input  logic load,
    output logic q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= 1'b0;
        end else if (load) begin
            q <= d_load;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Run/stop sequencer driving WIDTH T flip-flop stages as an up/down counter;
// TFF_COUNT_CTRL_AUTO_RELOAD_EN reloads load_val at the limit instead of stopping.
// Latency: count moves one edge after start is accepted. Backpressure: none.
module tff_count_ctrl
    import tff_count_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] toggle_vec;
    logic [WIDTH-1:0] start_cnt;
    logic             at_limit;
    logic             reload_now;
    logic             stage_load;
    logic             carry;

    assign at_limit  = (count == limit_q);
    assign start_cnt = load ? load_val : count;

`ifdef TFF_COUNT_CTRL_AUTO_RELOAD_EN
    assign reload_now = (state == RUN) && !stop && at_limit;
`else
    assign reload_now = 1'b0;
`endif

    assign stage_load = ((state == IDLE) && load) || reload_now;

    // Ripple-carry style enables: stage i toggles when all lower bits are
    // ones (up) or all zeros (down).
    always_comb begin
        toggle_vec = '0;
        carry      = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle_vec[i] = carry;
            carry = carry & ((dir_q == DIR_DOWN) ? ~count[i] : count[i]);
        end
        t_en = ((state == RUN) && !at_limit) ? toggle_vec : '0;
    end

    // stop gates the stages directly so t_en itself stays free of input paths.
    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        tff_stage u_stage (
            .clk    (clk),
            .clrn   (clrn),
            .t      (t_en[g] & ~stop),
            .d_load (load_val[g]),
            .load   (stage_load),
            .q      (count[g])
        );
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q   <= dir;
                        limit_q <= limit;
                        if (start_cnt == limit) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (at_limit) begin
`ifdef TFF_COUNT_CTRL_AUTO_RELOAD_EN
                        done  <= 1'b1;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed vector bench for tff_count_ctrl with WIDTH=4.
module tb_tff_count_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clrn;
    logic         start, stop, dir, load;
    logic [W-1:0] load_val, limit;
    logic [W-1:0] t_en, count;
    logic         busy, done;

    int errors = 0;
    int checks = 0;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .t_en     (t_en),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         st;
        logic         sp;
        logic         dr;
        logic         ld;
        logic [W-1:0] lv;
        logic [W-1:0] lm;
        logic [W-1:0] e_count;
        logic [W-1:0] e_t;
        logic         chk_t;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t rows[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic dr, input logic ld,
                                input logic [W-1:0] lv, input logic [W-1:0] lm,
                                input logic [W-1:0] ec, input logic [W-1:0] et,
                                input logic ct, input logic eb, input logic ed);
        vec_t v;
        v.st = st; v.sp = sp; v.dr = dr; v.ld = ld; v.lv = lv; v.lm = lm;
        v.e_count = ec; v.e_t = et; v.chk_t = ct; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic dr, input logic ld,
                         input logic [W-1:0] lv, input logic [W-1:0] lm);
        start = st; stop = sp; dir = dr; load = ld; load_val = lv; limit = lm;
    endtask

    initial begin
        clrn = 1'b0;
        drive(0, 0, 0, 0, '0, '0);

`ifdef TFF_COUNT_CTRL_AUTO_RELOAD_EN
        // reload loop 1,2,3,1,... with done each reload, then stop
        rows.push_back(mk(1,0,1,1, 1,3,  0,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 1,0,  1,4'b0011,1,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  2,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  3,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  1,4'b0011,1,1,1));
        rows.push_back(mk(0,0,0,0, 1,0,  2,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  3,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  1,4'b0011,1,1,1));
        rows.push_back(mk(0,1,0,0, 1,0,  2,4'b0000,0,1,0));
        rows.push_back(mk(0,0,0,0, 1,0,  2,4'b0000,1,0,0));
        // start with load_val == limit still goes through DONE once
        rows.push_back(mk(1,0,1,1, 4,4,  2,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 4,0,  4,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 4,0,  4,4'b0000,1,0,0));
`else
        // load+start up 3..7, RUN ignores load/start/dir/limit, DONE ignores load
        rows.push_back(mk(1,0,1,1, 3,7,   0,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,   3,4'b0111,1,1,0));
        rows.push_back(mk(1,0,1,1, 9,2,   4,4'b0001,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,   5,4'b0011,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,   6,4'b0001,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,   7,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,1, 0,0,   7,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,   7,4'b0000,1,0,0));
        // start with count already at limit
        rows.push_back(mk(1,0,1,0, 0,7,   7,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,   7,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,   7,4'b0000,1,0,0));
        // down 2,1,0,15,14 across the wrap
        rows.push_back(mk(1,0,0,1, 2,14,  7,4'b0000,1,0,0));
        rows.push_back(mk(0,0,1,0, 0,0,   2,4'b0011,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,   1,4'b0001,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,   0,4'b1111,1,1,0));
        rows.push_back(mk(0,0,1,0, 0,0,  15,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,  14,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,  14,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,  14,4'b0000,1,0,0));
        // up from 0 to 9, stopped at 5, restarted
        rows.push_back(mk(1,0,1,1, 0,9,  14,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,   0,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   1,4'b0011,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   2,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   3,4'b0111,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   4,4'b0001,1,1,0));
        rows.push_back(mk(0,1,1,0, 0,0,   5,4'b0000,0,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   5,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,   5,4'b0000,1,0,0));
        rows.push_back(mk(1,0,1,0, 0,9,   5,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,   5,4'b0011,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,6,   6,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   7,4'b1111,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   8,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   9,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   9,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,   9,4'b0000,1,0,0));
        // up wrap 15 -> 0 is not terminal
        rows.push_back(mk(1,0,1,1, 15,1,  9,4'b0000,1,0,0));
        rows.push_back(mk(0,0,0,0, 0,0,  15,4'b1111,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   0,4'b0001,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   1,4'b0000,1,1,0));
        rows.push_back(mk(0,0,0,0, 0,0,   1,4'b0000,1,0,1));
        rows.push_back(mk(0,0,0,0, 0,0,   1,4'b0000,1,0,0));
`endif

        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", -1, count, 4'd0);
        chk("reset_t_en",  -1, t_en,  4'd0);
        chk("reset_busy",  -1, {3'b0, busy}, 4'd0);
        chk("reset_done",  -1, {3'b0, done}, 4'd0);
        clrn = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            drive(rows[i].st, rows[i].sp, rows[i].dr, rows[i].ld, rows[i].lv, rows[i].lm);
            #1;
            chk("count", i, count, rows[i].e_count);
            chk("busy",  i, {3'b0, busy}, {3'b0, rows[i].e_busy});
            chk("done",  i, {3'b0, done}, {3'b0, rows[i].e_done});
            if (rows[i].chk_t) chk("t_en", i, t_en, rows[i].e_t);
        end

        // asynchronous reset asserted between edges while running at count 5
        @(negedge clk);
        drive(1, 0, 1, 1, 4'd5, 4'd12);
        @(negedge clk);
        drive(0, 0, 0, 0, 4'd0, 4'd0);
        #1;
        chk("pre_rst_count", 100, count, 4'd5);
        chk("pre_rst_busy",  100, {3'b0, busy}, 4'd1);
        #2;
        clrn = 1'b0;
        #1;
        chk("async_rst_count", 101, count, 4'd0);
        chk("async_rst_busy",  101, {3'b0, busy}, 4'd0);
        chk("async_rst_t_en",  101, t_en, 4'd0);
        chk("async_rst_done",  101, {3'b0, done}, 4'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_count", 102, count, 4'd0);
        chk("post_rst_busy",  102, {3'b0, busy}, 4'd0);
        chk("post_rst_t_en",  102, t_en, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
